// File: rtl/ps2_pkg.sv
// Frame constants, odd-parity helper and receiver state encoding shared by the PS/2 host tx and rx.
package ps2_pkg;

    localparam int   DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Parity bit that makes the total number of ones (data + parity) odd.
    function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_cond.sv
// One PS/2 line: 2-flop synchroniser, FILTER_LEN-sample glitch filter, registered falling-edge pulse.
// Pulse appears 2 + FILTER_LEN + 1 cycles after a clean raw edge; no backpressure.
module ps2_line_cond #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic fall_o
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic          meta_q;
    logic          sync_q;
    logic          filt_q;
    logic          filt_d;
    logic          fall_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // cnt_q counts consecutive samples that disagree with the filtered level; any agreeing sample restarts it.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync_q != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            filt_q <= 1'b1;
            cnt_q  <= '0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
            fall_q <= filt_q & ~filt_d;
        end
    end

    assign fall_o = fall_q;

endmodule

// File: rtl/ps2_host_rx.sv
// Host-side PS/2 frame receiver with clock glitch filter and inter-edge watchdog.
// Result pulses and rx_data register one cycle after the stop-bit sample; no backpressure, rx_en low aborts silently.
module ps2_host_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN   = 8,
    parameter int TIMEOUT_BITS = 13
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    input  logic       rx_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_parity_err,
    output logic       rx_frame_err,
    output logic       rx_timeout,
    output logic       rx_busy
);

    localparam int BCW = $clog2(DATA_BITS);

    logic                    sample;
    logic                    dmeta_q;
    logic                    dsync_q;

    rx_state_t               state_q,  state_d;
    logic [BCW-1:0]          bitcnt_q, bitcnt_d;
    logic [DATA_BITS-1:0]    shift_q,  shift_d;
    logic                    par_q,    par_d;
    logic [TIMEOUT_BITS-1:0] wdog_q,   wdog_d;
    logic [DATA_BITS-1:0]    data_q,   data_d;
    logic                    valid_q,  valid_d;
    logic                    perr_q,   perr_d;
    logic                    ferr_q,   ferr_d;
    logic                    to_q,     to_d;

    ps2_line_cond #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_cond (
        .clk    (clk),
        .rst    (rst),
        .line_i (ps2_clk_in),
        .fall_o (sample)
    );

    // Data is only synchronised: it is stable for many cycles around each clock fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            dmeta_q <= 1'b1;
            dsync_q <= 1'b1;
        end else begin
            dmeta_q <= ps2_data_in;
            dsync_q <= dmeta_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        wdog_d   = wdog_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        perr_d   = 1'b0;
        ferr_d   = 1'b0;
        to_d     = 1'b0;

        if (!rx_en) begin
            state_d = RX_IDLE;
            wdog_d  = '0;
            shift_d = '0;
        end else if (state_q == RX_IDLE) begin
            wdog_d = '0;
            if (sample && dsync_q == START_BIT) begin
                state_d  = RX_DATA;
                bitcnt_d = '0;
                shift_d  = '0;
                wdog_d   = '1;
            end
        end else if (sample) begin
            // A sample event always beats a simultaneous watchdog expiry.
            wdog_d = '1;
            case (state_q)
                RX_DATA: begin
                    shift_d  = {dsync_q, shift_q[DATA_BITS-1:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == BCW'(DATA_BITS - 1)) begin
                        state_d = RX_PARITY;
                    end
                end
                RX_PARITY: begin
                    par_d   = dsync_q;
                    state_d = RX_STOP;
                end
                RX_STOP: begin
                    state_d = RX_IDLE;
                    wdog_d  = '0;
                    if (dsync_q != STOP_BIT) begin
                        ferr_d = 1'b1;
                    end else if (par_q != odd_parity(shift_q)) begin
                        perr_d = 1'b1;
                    end else begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end else if (wdog_q == '0 || wdog_q == TIMEOUT_BITS'(1)) begin
            to_d    = 1'b1;
            state_d = RX_IDLE;
            wdog_d  = '0;
            shift_d = '0;
        end else begin
            wdog_d = wdog_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RX_IDLE;
            bitcnt_q <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            wdog_q   <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            wdog_q   <= wdog_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            to_q     <= to_d;
        end
    end

    assign rx_data       = data_q;
    assign rx_valid      = valid_q;
    assign rx_parity_err = perr_q;
    assign rx_frame_err  = ferr_q;
    assign rx_timeout    = to_q;
    assign rx_busy       = (state_q != RX_IDLE);

endmodule

// File: doc/ps2_host_rx.md
Name: ps2_host_rx

Overview:
- Host-side PS/2 receiver. Deserialises device-to-host 11-bit frames: start 0, 8 data bits LSB first, odd parity, stop 1.
- Sits beside the host transmitter on the same ps2_clk/ps2_data pins.
- Delivers a byte with a 1-cycle valid strobe, or a 1-cycle error pulse.
- Provides the clock-line glitch filtering and the inter-bit watchdog that the keyboard path needs.

Parameters:
- FILTER_LEN, default 8: number of consecutive identical synchronised ps2_clk samples required before the filtered clock changes.
- TIMEOUT_BITS, default 13: width of the inter-edge watchdog counter. Timeout period is 2^TIMEOUT_BITS-1 clk cycles.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-high
- ps2_clk_in  input  1  raw PS/2 clock line (asynchronous)
- ps2_data_in  input  1  raw PS/2 data line (asynchronous)
- rx_en  input  1  receiver enable; driven low by the host while the transmitter owns the bus
- rx_data  output  8  last correctly received byte
- rx_valid  output  1  1-cycle pulse: new byte on rx_data
- rx_parity_err  output  1  1-cycle pulse: parity mismatch, byte dropped
- rx_frame_err  output  1  1-cycle pulse: stop bit sampled 0, byte dropped
- rx_timeout  output  1  1-cycle pulse: frame aborted by the watchdog
- rx_busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset:
  - All outputs 0; rx_data = 0x00.
  - Sync flops and filtered clock = 1; FSM in IDLE; shift register 0; watchdog 0.
- Input conditioning:
  - Both lines pass through 2-flop synchronisers.
  - Filtered clock takes the synchronised value only after FILTER_LEN consecutive equal samples.
  - Sample event = 1->0 transition of the filtered clock (1-cycle pulse).
  - Data is taken from synchronised data in the same cycle as the sample event.
- FSM states:
  - IDLE: on a sample event with data=0, go to DATA, bit count = 0, load watchdog. Data=1 at the event is ignored: no flag, stay in IDLE.
  - DATA: on each sample event, shift data into bit 7 (shift right), count+1. After the 8th bit go to PARITY.
  - PARITY: on a sample event, capture the parity bit and go to STOP.
  - STOP: on a sample event, evaluate the frame and return to IDLE:
    - stop bit = 0 -> rx_frame_err. Takes precedence over parity.
    - else XOR of (8 data bits, parity bit) = 0 -> rx_parity_err.
    - else rx_valid, and rx_data updated on the same edge.
- Latency: the pulse outputs and rx_data are registered and assert on the clk edge following the stop-bit sample event.
- rx_data changes only with rx_valid; it holds its value across errors and timeouts.
- Watchdog:
  - Loaded with all ones on every sample event outside IDLE; decrements each cycle outside IDLE.
  - On reaching 0 outside IDLE: pulse rx_timeout, go to IDLE, discard the partial byte.
  - Held at 0 in IDLE.
- Simultaneous events:
  - Sample event and watchdog expiry in the same cycle: the sample event wins (reload, no timeout).
  - rx_en low has priority over everything. It forces IDLE the next cycle with no pulses, including when it coincides with the stop-bit event.
  - Conditioning logic keeps running while rx_en is low.
- Mid-operation rst returns everything to the reset values; no pulse is emitted.
- At most one of rx_valid, rx_parity_err, rx_frame_err, rx_timeout is high in any cycle.

Decomposition:
- Shared package ps2_pkg, used by both host tx and rx:
  - frame constants: DATA_BITS=8, START_BIT=0, STOP_BIT=1;
  - the odd-parity function;
  - the rx state enumeration.
- One sub-module, ps2_line_cond: synchroniser, FILTER_LEN glitch filter and negedge pulse for one line. It is instantiated for clk (filtered) and is reusable by the transmitter.

Test Plan (FILTER_LEN=8, TIMEOUT_BITS=8; device model toggles ps2_clk at 40 cycles per half-period):
- Frame 0xA5, parity 1, stop 1 -> exactly one rx_valid pulse, rx_data=0xA5, no error pulses, rx_busy low after the stop bit.
- After 0xA5, send 0x3C with parity 0 (wrong) -> one rx_parity_err pulse, no rx_valid, rx_data stays 0xA5.
- Frame 0x12, correct parity 1, stop 0 -> one rx_frame_err pulse only, rx_data unchanged. Repeat with bad parity as well -> still rx_frame_err only.
- Send start plus 4 data bits, then hold clk high for 300 cycles -> rx_timeout pulse about 255 cycles after the last edge, rx_busy drops. A following 0xF0 frame -> rx_valid, rx_data=0xF0.
- Inject 3-cycle low glitches on ps2_clk in IDLE and mid-frame -> no extra bits shifted. A 0x55 frame with glitches still yields rx_data=0x55.
- Drop rx_en after 6 bits, raise it 100 cycles later -> no pulses, rx_busy low. The next frame 0xAA is received correctly.
